// File: rtl/div_seq_unit.sv
// -----------------------------------------------------------------------------
// div_seq_unit
//  Multi-cycle restoring divider feeding the HiLo register.
//  ALU control issues a DIVU/DIV funct together with a one-cycle start pulse.
//  The block produces one quotient bit per cycle and returns
//  DivAns = {remainder, quotient}, so Hi = remainder and Lo = quotient.
//
//  Optional feature macro: SIGNED_DIV_EN
//   - defined:   FUNCT_DIV performs a signed divide. Magnitudes are taken at
//                capture, and the signs are corrected when entering DONE.
//   - undefined: FUNCT_DIV behaves exactly like FUNCT_DIVU (no sign logic).
//
//  Ports
//   clk     in   1        rising-edge clock
//   reset   in   1        synchronous, active-low reset
//   start   in   1        one-cycle request, sampled only in IDLE
//   Signal  in   6        funct field, sampled with start
//   dataA   in   WIDTH    dividend, sampled with start
//   dataB   in   WIDTH    divisor, sampled with start
//   busy    out  1        high in RUN and DONE
//   done    out  1        one-cycle pulse; DivAns is valid in this cycle
//   DivAns  out  2*WIDTH  {remainder, quotient}; holds until next DONE/reset
//
//  Handshake: a request is accepted when start is high in an IDLE cycle and
//  Signal is a divide funct. The cycle after acceptance busy rises. start is
//  ignored while busy (no queueing, no restart). Exactly WIDTH+1 cycles after
//  the accepting cycle, done pulses for one cycle with DivAns already valid.
//  Then busy drops on the following cycle.
// -----------------------------------------------------------------------------
module div_seq_unit #(
  parameter int          WIDTH      = 32,
  parameter logic [5:0]  FUNCT_DIVU = 6'b011011,
  parameter logic [5:0]  FUNCT_DIV  = 6'b011010
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [5:0]         Signal,
  input  logic [WIDTH-1:0]   dataA,
  input  logic [WIDTH-1:0]   dataB,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] DivAns
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] qReg;
  logic [WIDTH-1:0] divReg;
  logic [WIDTH:0]   remReg;
  logic [CW-1:0]    count;

  logic             accept;
  logic             lastIter;
  logic [WIDTH+1:0] trial;
  logic             trialNeg;
  logic [WIDTH:0]   nextRem;
  logic [WIDTH-1:0] nextQ;
  logic [WIDTH-1:0] capA;
  logic [WIDTH-1:0] capB;
  logic [WIDTH-1:0] finalQ;
  logic [WIDTH-1:0] finalR;

  assign accept   = (state == IDLE) && start &&
                    ((Signal == FUNCT_DIVU) || (Signal == FUNCT_DIV));
  assign lastIter = (count == CW'(WIDTH - 1));
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);

  // The trial subtraction is one bit wider than the remainder so that its MSB
  // is a clean borrow flag even when {rem, qbit} reaches 2*divisor-1.
  always_comb begin
    trial    = {remReg, qReg[WIDTH-1]} - {2'b00, divReg};
    trialNeg = trial[WIDTH+1];
    nextRem  = trialNeg ? {remReg[WIDTH-1:0], qReg[WIDTH-1]} : trial[WIDTH:0];
    nextQ    = {qReg[WIDTH-2:0], ~trialNeg};
  end

`ifdef SIGNED_DIV_EN
  logic             negQ;
  logic             negR;
  logic             divZero;
  logic [WIDTH-1:0] origA;
  logic             isSigned;

  always_comb begin
    isSigned = (Signal == FUNCT_DIV);
    capA     = (isSigned && dataA[WIDTH-1]) ? -dataA : dataA;
    capB     = (isSigned && dataB[WIDTH-1]) ? -dataB : dataB;
  end

  // A zero divisor bypasses sign correction: quotient all ones and the
  // remainder is the original (signed) dividend, matching the unsigned case.
  always_comb begin
    if (divZero) begin
      finalQ = '1;
      finalR = origA;
    end else begin
      finalQ = negQ ? -nextQ : nextQ;
      finalR = negR ? -nextRem[WIDTH-1:0] : nextRem[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      negQ    <= 1'b0;
      negR    <= 1'b0;
      divZero <= 1'b0;
      origA   <= '0;
    end else if (accept) begin
      negQ    <= isSigned && (dataA[WIDTH-1] ^ dataB[WIDTH-1]);
      negR    <= isSigned && dataA[WIDTH-1];
      divZero <= (dataB == '0);
      origA   <= dataA;
    end
  end
`else
  // With a zero divisor the restoring loop naturally yields quotient all
  // ones and remainder = dividend, so no special case is needed here.
  always_comb begin
    capA   = dataA;
    capB   = dataB;
    finalQ = nextQ;
    finalR = nextRem[WIDTH-1:0];
  end
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      qReg   <= '0;
      divReg <= '0;
      remReg <= '0;
      count  <= '0;
      DivAns <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            qReg   <= capA;
            divReg <= capB;
            remReg <= '0;
            count  <= '0;
            state  <= RUN;
          end
        end
        RUN: begin
          qReg   <= nextQ;
          remReg <= nextRem;
          count  <= count + CW'(1);
          if (lastIter) begin
            // Result is registered on the edge into DONE so it is valid
            // during the done pulse.
            DivAns <= {finalR, finalQ};
            state  <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq_unit.sv
module tb_div_seq_unit;

  localparam logic [5:0] F_DIVU = 6'b011011;
  localparam logic [5:0] F_DIV  = 6'b011010;

  logic        clk;
  logic        reset;
  logic        start;
  logic [5:0]  Signal;
  logic [31:0] dataA;
  logic [31:0] dataB;
  logic        busy;
  logic        done;
  logic [63:0] DivAns;

  int vectors;
  int miscompares;

  div_seq_unit dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .Signal (Signal),
    .dataA  (dataA),
    .dataB  (dataB),
    .busy   (busy),
    .done   (done),
    .DivAns (DivAns)
  );

  // clock block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance one cycle; outputs are sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // start a divide and wait for done with a cycle budget
  task automatic run_div(input string tag, input logic [5:0] f,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp);
    int lat;
    Signal = f;
    dataA  = a;
    dataB  = b;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    lat    = 1;
    while (!done && lat < 40) begin
      tick();
      lat++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'd33);
    chk({tag, "_ans"}, DivAns, exp);
    tick();
    chk({tag, "_busy_low"}, {63'd0, busy}, 64'd0);
  endtask

  initial begin
    int lat;
    int extra;
    vectors     = 0;
    miscompares = 0;
    reset  = 1'b0;
    start  = 1'b1;
    Signal = F_DIVU;
    dataA  = 32'd5;
    dataB  = 32'd1;

    // reset held with start high: nothing may start
    tick();
    tick();
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_ans", DivAns, 64'd0);
    reset = 1'b1;
    start = 1'b0;
    tick();
    chk("rst_release_busy", {63'd0, busy}, 64'd0);

    // basic unsigned divides, including busy timing
    run_div("divu_100_7", F_DIVU, 32'd100, 32'd7, {32'd2, 32'd14});
    run_div("divu_7_100", F_DIVU, 32'd7, 32'd100, {32'd7, 32'd0});
    run_div("divu_max_1", F_DIVU, 32'hFFFFFFFF, 32'd1, {32'd0, 32'hFFFFFFFF});
    run_div("divu_max_by0", F_DIVU, 32'hFFFFFFFF, 32'd0, {32'hFFFFFFFF, 32'hFFFFFFFF});
    run_div("divu_big", F_DIVU, 32'h80000000, 32'hFFFFFFFF, {32'h80000000, 32'd0});

    // an unrecognised funct is ignored; DivAns keeps the last result
    Signal = 6'b100000;
    dataA  = 32'd50;
    dataB  = 32'd5;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    chk("bad_funct_busy", {63'd0, busy}, 64'd0);
    chk("bad_funct_hold", DivAns, {32'h80000000, 32'd0});
    tick();

    // second start while busy is ignored; exactly one done
    Signal = F_DIVU;
    dataA  = 32'd1000;
    dataB  = 32'd30;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    dataA = 32'd9;
    dataB = 32'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    lat   = 6;
    while (!done && lat < 40) begin
      tick();
      lat++;
    end
    chk("busy_ign_latency", 64'(lat), 64'd33);
    chk("busy_ign_ans", DivAns, {32'd10, 32'd33});
    extra = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) extra++;
    end
    chk("busy_ign_one_done", 64'(extra), 64'd0);

    // reset in the middle of a divide
    dataA = 32'd1000;
    dataB = 32'd30;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    chk("midrst_ans", DivAns, 64'd0);
    extra = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) extra++;
    end
    chk("midrst_no_done", 64'(extra), 64'd0);
    run_div("after_rst_9_3", F_DIVU, 32'd9, 32'd3, {32'd0, 32'd3});

    // DIV funct: signed when the feature is built in, unsigned otherwise
`ifdef SIGNED_DIV_EN
    run_div("div_m7_2", F_DIV, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD});
    run_div("div_min_m1", F_DIV, 32'h80000000, 32'hFFFFFFFF, {32'd0, 32'h80000000});
    run_div("div_7_m2", F_DIV, 32'd7, 32'hFFFFFFFE, {32'd1, 32'hFFFFFFFD});
`else
    run_div("div_m7_2", F_DIV, 32'hFFFFFFF9, 32'd2, {32'h1, 32'h7FFFFFFC});
    run_div("div_min_m1", F_DIV, 32'h80000000, 32'hFFFFFFFF, {32'h80000000, 32'd0});
    run_div("div_7_m2", F_DIV, 32'd7, 32'hFFFFFFFE, {32'd7, 32'd0});
`endif
    // zero divisor gives the same answer in both builds
    run_div("div_m7_by0", F_DIV, 32'hFFFFFFF9, 32'd0, {32'hFFFFFFF9, 32'hFFFFFFFF});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
